// File: rtl/dnn_result_reader.sv
// Host-side sequencer for the MNIST engine: clear, start, wait for done, scan outputs, return signed argmax.
// Define DNN_TIMEOUT_EN to build the WAIT watchdog; otherwise res_err is tied to 0.
module dnn_result_reader #(
    parameter int DATA_WIDTH     = 4,
    parameter int NUM_CLASSES    = 10,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    output logic                         eng_reset,
    output logic                         eng_start,
    input  logic                         eng_done,
    output logic [IDX_WIDTH-1:0]         out_idx,
    input  logic signed [DATA_WIDTH-1:0] out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [IDX_WIDTH-1:0]         res_class,
    output logic signed [DATA_WIDTH-1:0] res_score,
    output logic                         res_err
);

    if ((2**IDX_WIDTH < NUM_CLASSES) || (NUM_CLASSES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
        $error("dnn_result_reader: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_START, S_WAIT, S_SCAN, S_DRAIN, S_RESULT
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                         state;
    logic                           wait_first;
    logic                           s_vld;
    logic [IDX_WIDTH-1:0]           s_idx;
    logic signed [DATA_WIDTH-1:0]   s_val;
    logic signed [DATA_WIDTH-1:0]   max_q;
    logic [IDX_WIDTH-1:0]           arg_q;
    logic                           upd;
    logic signed [DATA_WIDTH-1:0]   nmax;
    logic [IDX_WIDTH-1:0]           narg;

`ifdef DNN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    // Index 0 loads unconditionally; strict > keeps the lowest index on ties.
    always_comb begin
        upd  = s_vld && ((s_idx == '0) || (s_val > max_q));
        nmax = upd ? s_val : max_q;
        narg = upd ? s_idx : arg_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            eng_reset  <= 1'b0;
            eng_start  <= 1'b0;
            out_idx    <= '0;
            res_valid  <= 1'b0;
            res_class  <= '0;
            res_score  <= '0;
            wait_first <= 1'b0;
            s_vld      <= 1'b0;
            s_idx      <= '0;
            s_val      <= '0;
            max_q      <= '0;
            arg_q      <= '0;
`ifdef DNN_TIMEOUT_EN
            to_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            eng_reset <= 1'b0;
            eng_start <= 1'b0;
            s_vld     <= 1'b0;
            if (s_vld) begin
                max_q <= nmax;
                arg_q <= narg;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        eng_reset <= 1'b1;
                        state     <= S_CLR;
                    end
                end
                S_CLR: begin
                    eng_start <= 1'b1;
                    state     <= S_START;
                end
                S_START: begin
                    wait_first <= 1'b1;
`ifdef DNN_TIMEOUT_EN
                    to_cnt     <= '0;
`endif
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // A done level left over from the previous run is masked for one cycle.
                    wait_first <= 1'b0;
                    if (!wait_first && eng_done) begin
                        state <= S_SCAN;
                    end
`ifdef DNN_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        res_valid <= 1'b1;
                        res_class <= '0;
                        res_score <= '0;
                        err_q     <= 1'b1;
                        state     <= S_RESULT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                S_SCAN: begin
                    // out follows out_idx combinationally; capture it tagged with its index.
                    s_vld <= 1'b1;
                    s_idx <= out_idx;
                    s_val <= out;
                    if (out_idx == LAST_IDX) begin
                        out_idx <= '0;
                        state   <= S_DRAIN;
                    end else begin
                        out_idx <= out_idx + IDX_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    res_valid <= 1'b1;
                    res_class <= narg;
                    res_score <= nmax;
`ifdef DNN_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                    state     <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
`ifdef DNN_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    out_idx   <= '0;
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_result_reader.sv
// Bench for dnn_result_reader: table of score vectors with an engine model and a result scoreboard,
// plus hand-written reset-mid-scan and (with DNN_TIMEOUT_EN) watchdog sequences.
module tb_dnn_result_reader;
    localparam int DW = 4;
    localparam int NC = 10;
    localparam int IW = 4;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 eng_reset;
    logic                 eng_start;
    logic                 eng_done = 1'b0;
    logic [IW-1:0]        out_idx;
    logic signed [DW-1:0] out;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [IW-1:0]        res_class;
    logic signed [DW-1:0] res_score;
    logic                 res_err;

    logic [NC-1:0][DW-1:0] mem = '0;

    // Engine model: score selected combinationally by out_idx.
    assign out = (out_idx < IW'(NC)) ? mem[out_idx] : '0;

    always #5 clk = ~clk;

    dnn_result_reader #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
        .out_idx(out_idx), .out(out), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_score(res_score), .res_err(res_err)
    );

    typedef struct {
        logic [NC-1:0][DW-1:0] sc;
        int                    done_at;
        int                    stale_to;
        int                    bp;
        logic [IW-1:0]         cls;
        logic signed [DW-1:0]  score;
    } vec_t;

    typedef struct packed {
        logic [IW-1:0] c;
        logic [DW-1:0] s;
    } exp_t;

    exp_t sbq[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [NC-1:0][DW-1:0] pk(input int v[NC]);
        logic [NC-1:0][DW-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = DW'(v[i]);
        return r;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_eng_reset"}, eng_reset, 0);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_class"}, res_class, 0);
        check({tag, "_res_score"}, res_score, 0);
        check({tag, "_res_err"}, res_err, 0);
    endtask

    // Called at a negedge with the block idle; cycle 0 is the one presenting req_valid.
    task automatic run(input vec_t v);
        int   rv_at = -1, nrp = 0, nsp = 0, rp_t = -1, sp_t = -1, idx_bad = 0, rr_bad = 0, unstable = 0;
        int   exp_idx;
        exp_t e;
        mem = v.sc;
        check("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        sbq.push_back({v.cls, v.score});
        eng_done = (v.stale_to >= 0);
        for (int t = 1; t < 200 && rv_at < 0; t++) begin
            @(negedge clk);
            if (t == 1) req_valid = 1'b0;
            if (eng_reset) begin nrp++; rp_t = t; end
            if (eng_start) begin nsp++; sp_t = t; end
            if (req_ready) rr_bad++;
            exp_idx = (t > v.done_at && t <= v.done_at + NC) ? t - v.done_at - 1 : 0;
            if (int'(out_idx) != exp_idx) idx_bad++;
            if (res_valid) rv_at = t;
            eng_done = (t >= v.done_at) || (t <= v.stale_to);
        end
        check("eng_reset_pulses", nrp, 1);
        check("eng_reset_cycle", rp_t, 1);
        check("eng_start_pulses", nsp, 1);
        check("eng_start_cycle", sp_t, 2);
        check("out_idx_seq_errs", idx_bad, 0);
        check("req_ready_busy_errs", rr_bad, 0);
        check("res_valid_cycle", rv_at, v.done_at + NC + 2);
        check("res_err_normal", res_err, 0);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("res_class", res_class, e.c);
            check("res_score", $signed(res_score), $signed(e.s));
        end else begin
            check("scoreboard_empty", 1, 0);
        end
        if (v.bp > 0) begin
            req_valid = 1'b1;
            for (int i = 0; i < v.bp; i++) begin
                @(negedge clk);
                if (!res_valid || res_class != e.c || res_score != e.s || req_ready || eng_reset) unstable++;
            end
            check("backpressure_unstable", unstable, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("ack_res_valid", res_valid, 0);
        check("ack_req_ready", req_ready, 1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{pk('{1, -2, 3, 7, 0, -8, 2, 5, 6, 4}),         7, -1, 0,  4'd3, 4'sd7};
        vecs[1] = '{pk('{2, 6, 6, 1, 6, 0, 0, 0, 0, 0}),           4, -1, 20, 4'd1, 4'sd6};
        vecs[2] = '{pk('{-8, -8, -8, -8, -8, -8, -8, -8, -8, -8}), 6, -1, 0,  4'd0, -4'sd8};
        vecs[3] = '{pk('{7, 7, 7, 7, 7, 7, 7, 7, 7, 7}),           5, -1, 0,  4'd0, 4'sd7};
        vecs[4] = '{pk('{-3, -8, -1, -5, -2, -7, -4, -6, -8, -1}), 9, 3,  0,  4'd2, -4'sd1};
        vecs[5] = '{pk('{-8, -8, -8, -8, -8, -8, -8, -8, -8, 7}),  8, -1, 0,  4'd9, 4'sd7};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run(vecs[i]);

        // Asynchronous reset while out_idx=4 during SCAN.
        begin
            int bad = 0;
            mem = vecs[0].sc;
            req_valid = 1'b1;
            eng_done = 1'b0;
            for (int t = 1; t <= 12; t++) begin
                @(negedge clk);
                if (t == 1) req_valid = 1'b0;
                eng_done = (t >= 7);
            end
            check("midscan_out_idx", out_idx, 4);
            rst = 1'b0;
            #1;
            check_reset_vals("midscan_reset");
            eng_done = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            for (int t = 0; t < 30; t++) begin
                @(negedge clk);
                if (res_valid || eng_start || eng_reset || !req_ready) bad++;
            end
            check("post_reset_quiet", bad, 0);
            run(vecs[0]);
        end

`ifdef DNN_TIMEOUT_EN
        begin
            int rv_at = -1;
            req_valid = 1'b1;
            eng_done = 1'b0;
            for (int t = 1; t < 100 && rv_at < 0; t++) begin
                @(negedge clk);
                if (t == 1) req_valid = 1'b0;
                if (res_valid) rv_at = t;
            end
            check("timeout_cycle", rv_at, 3 + TO);
            check("timeout_err", res_err, 1);
            check("timeout_class", res_class, 0);
            check("timeout_score", res_score, 0);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("timeout_err_clear", res_err, 0);
            check("timeout_ack_valid", res_valid, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dnn_result_reader.md
Name: dnn_result_reader

Overview:
- Host-side controller for the MNIST inference engine's control and result-select interface.
- Accepts a classify request, then clears and starts the engine. Waits for done.
- Sweeps the engine's out_idx select over all class outputs and computes the signed argmax.
- Presents the class and score on a valid/ready result handshake.

Parameters:
- DATA_WIDTH, 4, width of the signed engine output score.
- NUM_CLASSES, 10, number of class outputs to scan (indices 0..NUM_CLASSES-1).
- IDX_WIDTH, 4, width of out_idx and res_class; must satisfy 2**IDX_WIDTH >= NUM_CLASSES.
- TIMEOUT_CYCLES, 65535, watchdog limit in WAIT; used only with DNN_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  host requests a classification.
- req_ready  output  1  block can accept a request.
- eng_reset  output  1  one-cycle clear pulse to the engine.
- eng_start  output  1  one-cycle start pulse to the engine.
- eng_done  input  1  engine completion level.
- out_idx  output  IDX_WIDTH  engine output select.
- out  input  DATA_WIDTH  selected engine score, signed, combinational from out_idx.
- res_valid  output  1  result available.
- res_ready  input  1  host accepts the result.
- res_class  output  IDX_WIDTH  argmax class index.
- res_score  output  DATA_WIDTH  signed maximum score.
- res_err  output  1  timeout flag; constant 0 without DNN_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1.
  - eng_reset=0, eng_start=0, out_idx=0.
  - res_valid=0, res_class=0, res_score=0, res_err=0.
- All outputs are registered.
- IDLE:
  - req_ready=1.
  - req_valid=1 completes the handshake and moves to CLR.
- CLR: eng_reset=1 for exactly one cycle, then START.
- START: eng_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - eng_done is ignored in the first WAIT cycle, which masks a stale done level.
  - From the second WAIT cycle on, eng_done=1 moves to SCAN.
- SCAN: lasts NUM_CLASSES cycles.
  - Scan counter k runs from 0 to NUM_CLASSES-1, and out_idx=k.
  - Since out_idx is registered, out is sampled one cycle after out_idx is driven with k. The pipeline tags each sample with its index.
  - The first sample (k=0) loads max and argmax unconditionally.
  - Each later sample updates only when it is strictly greater than max, using a signed compare. Ties keep the lowest index.
  - out_idx returns to 0 after the last index is driven.
- RESULT:
  - res_valid=1; res_class and res_score are held stable.
  - res_valid=1 and res_ready=1 in the same cycle moves to IDLE, with res_valid=0 the next cycle.
  - res_ready is ignored while res_valid=0.
- Latency:
  - Request accepted at cycle 0.
  - eng_reset at cycle 1.
  - eng_start at cycle 2.
  - WAIT entered at cycle 3.
  - If eng_done is first seen at cycle D (D >= 4), res_valid rises at cycle D+NUM_CLASSES+2.
- req_ready=0 in every state other than IDLE. A req_valid arriving mid-operation is not accepted and stays pending per the host's valid/ready rules.
- An asynchronous reset in any state aborts the operation immediately. No eng_start pulse is issued after reset.
- eng_done dropping during SCAN has no effect; the scan completes.
- Ranges:
  - res_class is always in 0..NUM_CLASSES-1.
  - res_score covers the full signed DATA_WIDTH range, including the most negative value (-8 for 4 bits).

Optional Feature:
- Macro: DNN_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse without eng_done, the block goes to RESULT with res_err=1, res_class=0, res_score=0.
  - res_err is cleared on the accepting res_ready handshake.
  - On a normal completion, res_err=0.
- Not defined:
  - No counter is built, and res_err is tied to 0.
  - WAIT waits indefinitely.

Test Plan:
- Reset, then req_valid=1 with scores [1,-2,3,7,0,-8,2,5,6,4] and eng_done rising 5 cycles after eng_start -> exactly one eng_reset pulse, then one eng_start pulse; out_idx steps 0..9; res_class=3, res_score=7; cycle count matches the latency formula.
- Tie: scores [2,6,6,1,6,0,0,0,0,0] -> res_class=1, res_score=6.
- All scores -8 -> res_class=0, res_score=-8; all scores 7 -> res_class=0, res_score=7.
- Stale done: eng_done held at 1 from the previous run until eng_reset -> the first WAIT cycle is ignored; scanning starts only after eng_done is seen in a later cycle.
- Backpressure: res_ready=0 for 20 cycles, new req_valid held at 1 -> res_valid, res_class and res_score stay stable, req_ready=0; res_ready=1 -> IDLE next cycle, and the new request is accepted one cycle later.
- rst=0 mid-SCAN at k=4 -> all outputs at reset values immediately; no result is produced. With DNN_TIMEOUT_EN and TIMEOUT_CYCLES=16, eng_done never asserted -> res_valid=1 with res_err=1 after 16 WAIT cycles.
